// File: rtl/cga_vram_pkg.sv
// Shared types and constants for the CGA video RAM arbiter.
package cga_vram_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_PIX  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_t;

    // Below this fill the pixel side outranks the CPU.
    function automatic int urgent_thresh(input int depth);
        return depth / 2;
    endfunction

endpackage

// File: rtl/cga_vram_prefetch_fifo.sv
// Pixel prefetch FIFO: synchronous, flush wins over push/pop, level output.
// The caller guarantees it never pushes into a full FIFO.
module cga_vram_prefetch_fifo
    import cga_vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_din,
    input  logic                        i_pop,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_do_pop;

    assign w_do_pop = i_pop && (r_level != '0);

    // Pointer and level bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; the output is masked while empty.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush && i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_valid = (r_level != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_level;

endmodule

// File: rtl/cga_vram_arb.sv
// CGA video RAM: one single-port array shared by the ISA CPU port and a
// sequential pixel prefetch engine, one access per clock.
// Optional CGA_SNOW_EN: CPU always wins and corrupts the next pixel byte
// whenever it steals a slot the pixel side wanted (80-column snow).
module cga_vram_arb
    import cga_vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [18:0]       i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_din,
    input  logic              i_cpu_read,
    input  logic              i_cpu_write,
    output logic [DATA_W-1:0] o_cpu_dout,
    output logic              o_cpu_ready,
    input  logic              i_pix_start,
    input  logic [18:0]       i_pix_addr,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_pix_pop
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W:0] URGENT_L = (LVL_W+1)'(urgent_thresh(FIFO_DEPTH));
    localparam logic [LVL_W:0] DEPTH_L  = (LVL_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_ram [2**ADDR_W];
    logic [DATA_W-1:0] r_ram_q;
    logic              r_pend;
    logic              r_pend_wr;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_din;
    logic              r_cpu_ready;
    logic [ADDR_W-1:0] r_fetch_ptr;
    logic              r_pix_inflight;

    gnt_t              w_gnt;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W:0]    w_fill;
    logic              w_pix_want;
    logic              w_pix_urgent;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_unused;

    assign w_unused = ^{i_cpu_addr[18:ADDR_W], i_pix_addr[18:ADDR_W]};

    // Fill counts the read already issued but not yet pushed, so the FIFO
    // can never be over-committed. No fetch is issued while the pointer is
    // being reloaded.
    assign w_fill       = {1'b0, w_level} + (LVL_W+1)'(r_pix_inflight);
    assign w_pix_want   = !i_pix_start && (w_fill < DEPTH_L);
    assign w_pix_urgent = !i_pix_start && (w_fill < URGENT_L);

    // Slot arbitration for this cycle.
    always_comb begin
        w_gnt = GNT_IDLE;
`ifdef CGA_SNOW_EN
        if (r_pend)          w_gnt = GNT_CPU;
        else if (w_pix_want) w_gnt = GNT_PIX;
`else
        if (w_pix_urgent)    w_gnt = GNT_PIX;
        else if (r_pend)     w_gnt = GNT_CPU;
        else if (w_pix_want) w_gnt = GNT_PIX;
`endif
    end

    assign w_ram_addr = (w_gnt == GNT_CPU) ? r_pend_addr : r_fetch_ptr;

    // Single-port RAM, write-first so the read register carries the CPU bus byte.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && (w_gnt == GNT_CPU) && r_pend_wr) begin
            r_ram[r_pend_addr] <= r_pend_din;
            r_ram_q            <= r_pend_din;
        end else begin
            r_ram_q <= r_ram[w_ram_addr];
        end
    end

    // CPU pending slot, completion pulse, fetch pointer and in-flight tag.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pend         <= 1'b0;
            r_pend_wr      <= 1'b0;
            r_pend_addr    <= '0;
            r_pend_din     <= '0;
            r_cpu_ready    <= 1'b0;
            r_fetch_ptr    <= '0;
            r_pix_inflight <= 1'b0;
        end else begin
            r_cpu_ready    <= (w_gnt == GNT_CPU);
            r_pix_inflight <= (w_gnt == GNT_PIX);
            if (w_gnt == GNT_CPU) begin
                r_pend <= 1'b0;
            end else if (!r_pend && (i_cpu_read || i_cpu_write)) begin
                r_pend      <= 1'b1;
                r_pend_wr   <= i_cpu_write;
                r_pend_addr <= i_cpu_addr[ADDR_W-1:0];
                r_pend_din  <= i_cpu_din;
            end
            if (i_pix_start)
                r_fetch_ptr <= i_pix_addr[ADDR_W-1:0];
            else if (w_gnt == GNT_PIX)
                r_fetch_ptr <= r_fetch_ptr + ADDR_W'(1);
        end
    end

    // A read landing during pix_start belongs to the old stream: drop it.
    assign w_push = r_pix_inflight && !i_pix_start;

`ifdef CGA_SNOW_EN
    logic              r_snow_req;
    logic              r_snow;
    logic [DATA_W-1:0] r_snow_byte;

    // Arm snow on a contested CPU grant; the CPU byte is in r_ram_q one
    // cycle later, before any pixel read issued after the grant can land.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_snow_req  <= 1'b0;
            r_snow      <= 1'b0;
            r_snow_byte <= '0;
        end else begin
            r_snow_req <= (w_gnt == GNT_CPU) && w_pix_want;
            if (i_pix_start) begin
                r_snow <= 1'b0;
            end else if (r_snow_req) begin
                r_snow      <= 1'b1;
                r_snow_byte <= r_ram_q;
            end else if (w_push) begin
                r_snow <= 1'b0;
            end
        end
    end

    assign w_push_data = r_snow ? r_snow_byte : r_ram_q;
`else
    assign w_push_data = r_ram_q;
`endif

    cga_vram_prefetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_pix_start),
        .i_push    (w_push),
        .i_din     (w_push_data),
        .i_pop     (i_pix_pop),
        .o_valid   (o_pix_valid),
        .o_data    (o_pix_data),
        .o_level   (w_level)
    );

    assign o_cpu_ready = r_cpu_ready;
    assign o_cpu_dout  = r_cpu_ready ? r_ram_q : '0;

endmodule

// File: tb/tb_cga_vram_arb.sv
// Scoreboard bench for cga_vram_arb: stimulus pushes expectations, negedge
// monitors pop and compare whenever the DUT presents cpu_ready or a pixel pop.
module tb_cga_vram_arb;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [18:0]   cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ready;
    logic          pix_start;
    logic [18:0]   pix_addr;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_pop;

    always #5 clk = ~clk;

    cga_vram_arb #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_din   (cpu_din),
        .i_cpu_read  (cpu_read),
        .i_cpu_write (cpu_write),
        .o_cpu_dout  (cpu_dout),
        .o_cpu_ready (cpu_ready),
        .i_pix_start (pix_start),
        .i_pix_addr  (pix_addr),
        .o_pix_valid (pix_valid),
        .o_pix_data  (pix_data),
        .i_pix_pop   (pix_pop)
    );

    typedef struct {
        bit            rd;
        logic [DW-1:0] d;
        int            c;
        bit            exact;
    } cpu_exp_t;

    // Reference model: the byte array as the CPU sees it, plus which bytes are known.
    logic [DW-1:0] ref_mem [2**AW];
    bit            ref_ok  [2**AW];
    cpu_exp_t      cpu_q [$];
    logic [DW-1:0] pix_q [$];

    int cyc      = 0;
    int n_chk    = 0;
    int n_pass   = 0;
    int cpu_done = 0;
    int pop_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input int act, input int exp_v);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Pop driver: 0 = never, 1 = every cycle, 2 = random.
    initial begin
        pix_pop = 1'b0;
        forever begin
            @(posedge clk); #1;
            pix_pop = (pop_mode == 1) || (pop_mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // Monitors.
    initial begin
        cpu_exp_t      e;
        int            lat;
        logic [DW-1:0] ex;
        forever begin
            @(negedge clk);
            if (reset_n && cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    check(1'b0, "cpu_spurious_ready", 1, 0);
                end else begin
                    e   = cpu_q.pop_front();
                    lat = cyc - e.c;
                    if (e.exact) check(lat == 2, "cpu_latency", lat, 2);
                    else         check(lat >= 2 && lat <= 2 + FD/2, "cpu_latency_bound", lat, 2 + FD/2);
                    if (e.rd) check(cpu_dout == e.d, "cpu_dout", int'(cpu_dout), int'(e.d));
                    cpu_done++;
                end
            end
            if (reset_n && !pix_start && pix_pop && pix_valid) begin
                if (pix_q.size() == 0) begin
                    check(1'b0, "pix_extra_byte", int'(pix_data), 0);
                end else begin
                    ex = pix_q.pop_front();
                    check(pix_data == ex, "pix_data", int'(pix_data), int'(ex));
                end
            end
        end
    end

    task automatic cpu_op(input bit wr, input bit rd, input int a, input logic [DW-1:0] d,
                          input bit exact);
        cpu_exp_t e;
        int       n0;
        @(posedge clk); #1;
        n0      = cpu_done;
        e.rd    = !wr;
        e.c     = cyc;
        e.exact = exact;
        e.d     = wr ? d : ref_mem[14'(a)];
        if (wr) begin
            ref_mem[14'(a)] = d;
            ref_ok[14'(a)]  = 1'b1;
        end
        cpu_q.push_back(e);
        cpu_addr  = {5'($urandom), 14'(a)};
        cpu_din   = d;
        cpu_write = wr;
        cpu_read  = rd;
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_din   = DW'($urandom);
        for (int i = 0; i < 12 && cpu_done == n0; i++) @(posedge clk);
        #1;
        if (cpu_done == n0) check(1'b0, "cpu_timeout", 0, 1);
    endtask

    task automatic load_stream(input int a, input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(ref_mem[14'(a + i)]);
        pix_addr = {5'($urandom), 14'(a)};
    endtask

    task automatic pix_go(input int a, input int n);
        @(posedge clk); #1;
        load_stream(a, n);
        pix_start = 1'b1;
        @(posedge clk); #1;
        pix_start = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n0;
        int       c0;
        int       a;
        int       op;
        bit       seen;
        cpu_exp_t e;

        reset_n   = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        cpu_read  = 1'b1;
        cpu_write = 1'b1;
        pix_start = 1'b0;
        pix_addr  = '0;
        for (int i = 0; i < 2**AW; i++) ref_ok[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(cpu_ready == 1'b0, "rst_cpu_ready", int'(cpu_ready), 0);
        check(cpu_dout == '0,    "rst_cpu_dout",  int'(cpu_dout), 0);
        check(pix_valid == 1'b0, "rst_pix_valid", int'(pix_valid), 0);
        check(pix_data == '0,    "rst_pix_data",  int'(pix_data), 0);
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        reset_n   = 1'b1;

        // Known contents in the streamed regions.
        for (int i = 0; i < 'h200; i++) cpu_op(1'b1, 1'b0, i, DW'($urandom), 1'b0);
        for (int i = 'h3FF0; i < 'h4000; i++) cpu_op(1'b1, 1'b0, i, DW'($urandom), 1'b0);

        // A write caught by reset is dropped and leaves RAM untouched.
        @(posedge clk); #1;
        n0        = cpu_done;
        cpu_addr  = 19'h00010;
        cpu_din   = ~ref_mem[14'h0010];
        cpu_write = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset_n   = 1'b1;
        repeat (3) @(posedge clk); #1;
        check(cpu_done == n0, "reset_drops_cpu", cpu_done - n0, 0);
        cpu_op(1'b0, 1'b1, 'h10, 8'h00, 1'b0);

        // Fill from 0 with no pops: first byte within 3 cycles, stops at 4 entries.
        @(posedge clk); #1;
        c0 = cyc;
        load_stream(0, 64);
        pix_start = 1'b1;
        @(posedge clk); #1;
        pix_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = pix_valid;
        end
        check(seen && (cyc - c0) <= 3, "pix_valid_latency", cyc - c0, 3);
        repeat (8) @(posedge clk);
        // 0x0004 must not have been prefetched yet, so the new value shows up.
        cpu_op(1'b1, 1'b0, 'h0004, 8'hC3, 1'b1);
        pix_q[4] = 8'hC3;
        cpu_op(1'b1, 1'b0, 'h0123, 8'hA5, 1'b1);
        cpu_op(1'b0, 1'b1, 'h0123, 8'h00, 1'b1);
        pop_mode = 1;
        repeat (12) @(posedge clk);

        // Wrap at the top of the array.
        pix_go('h3FFE, 64);
        repeat (10) @(posedge clk);
`ifndef CGA_SNOW_EN
        // CPU reads against a continuously drained stream.
        for (int i = 0; i < 4; i++) cpu_op(1'b0, 1'b1, 'h3FF0 + i, 8'h00, 1'b0);
`endif

        // Restart while a read is in flight: the stale byte must not appear.
        pix_go('h0000, 64);
        repeat (5) @(posedge clk);
        pix_go('h0100, 64);
        repeat (10) @(posedge clk);

        // CPU write issued together with a stream restart.
        pop_mode = 0;
        repeat (6) @(posedge clk);
        @(posedge clk); #1;
        n0 = cpu_done;
        load_stream('h0040, 64);
        pix_start = 1'b1;
        e.rd  = 1'b0;
        e.d   = 8'h5A;
        e.c   = cyc;
`ifdef CGA_SNOW_EN
        e.exact  = 1'b1;
        pix_q[0] = 8'h5A;
`else
        e.exact = 1'b0;
`endif
        cpu_q.push_back(e);
        ref_mem[14'h0210] = 8'h5A;
        ref_ok[14'h0210]  = 1'b1;
        cpu_addr  = 19'h00210;
        cpu_din   = 8'h5A;
        cpu_write = 1'b1;
        @(posedge clk); #1;
        pix_start = 1'b0;
        cpu_write = 1'b0;
        for (int i = 0; i < 12 && cpu_done == n0; i++) @(posedge clk);
        #1;
        check(cpu_done == n0 + 1, "snow_cpu_done", cpu_done - n0, 1);
        repeat (5) @(posedge clk);
        pop_mode = 1;
        repeat (10) @(posedge clk);

        // Randomised episodes.
        for (int ep = 0; ep < 8; ep++) begin
            a = ($urandom_range(0, 1) == 1) ? int'($urandom_range('h3FF0, 'h3FFC))
                                            : int'($urandom_range(0, 'h100));
            pop_mode = int'($urandom_range(1, 2));
            pix_go(a, 128);
`ifndef CGA_SNOW_EN
            for (int k = 0; k < 5; k++) begin
                op = int'($urandom_range(0, 2));
                if (op == 1) begin
                    a = int'($urandom_range(0, 'h23F));
                    if (!ref_ok[14'(a)]) a = int'($urandom_range(0, 'h1FF));
                    cpu_op(1'b0, 1'b1, a, 8'h00, 1'b0);
                end else begin
                    cpu_op(1'b1, op == 2, int'($urandom_range('h200, 'h23F)), DW'($urandom), 1'b0);
                end
            end
`else
            repeat (20) @(posedge clk);
`endif
        end

        pop_mode = 0;
        repeat (6) @(posedge clk);
        check(cpu_q.size() == 0, "cpu_queue_drained", cpu_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
